// File: rtl/rr_stream_arbiter.sv
// Packet-granular round-robin arbiter: N valid/ready requesters share one
// registered downstream stream; the grant is held until the owner's last beat.
module rr_stream_arbiter #(
  parameter int L   = 8,
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     valid_f,
  output logic [N-1:0]     ready_f,
  input  logic [N*L-1:0]   data_f,
  input  logic [N-1:0]     last_f,
  input  logic             ready_b,
  output logic             valid_b,
  output logic [L-1:0]     data_b,
  output logic             last_b,
  output logic [IDW-1:0]   grant_id,
  output logic             busy
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, owner, sel;
  logic           found;
  logic           out_ready, xfer, xfer_last;
  logic [L-1:0]   beat [N];

  always_comb begin
    for (int i = 0; i < N; i++) beat[i] = data_f[i*L +: L];
  end

  // Wrapping priority search starting at ptr; sum stays below 2N so one subtract wraps.
  always_comb begin : pick
    logic [IDW:0] idx;
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(N)) idx = idx - (IDW+1)'(N);
      if (!found && valid_f[idx[IDW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IDW-1:0];
      end
    end
  end

  assign out_ready = ready_b || !valid_b;
  assign xfer      = (state == LOCK) && valid_f[owner] && out_ready;
  assign xfer_last = xfer && last_f[owner];
  assign busy      = (state == LOCK);

  always_comb begin
    state_nxt = state;
    ready_f   = '0;
    case (state)
      IDLE: if (found) state_nxt = LOCK;
      LOCK: begin
        ready_f[owner] = out_ready;
        if (xfer_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr   <= '0;
      owner <= '0;
    end else begin
      if (state == IDLE && found) owner <= sel;
      if (xfer_last) ptr <= (owner == IDW'(N-1)) ? '0 : owner + IDW'(1);
    end
  end

  // Output register: a new beat may load in the same cycle the old one drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_b  <= 1'b0;
      data_b   <= '0;
      last_b   <= 1'b0;
      grant_id <= '0;
    end else if (xfer) begin
      valid_b  <= 1'b1;
      data_b   <= beat[owner];
      last_b   <= last_f[owner];
      grant_id <= owner;
    end else if (valid_b && ready_b) begin
      valid_b  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Bench for rr_stream_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against a packet-level arbitration model.
module tb_rr_stream_arbiter;
  localparam int L = 8, N = 4, IDW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     valid_f, ready_f, last_f;
  logic [N*L-1:0]   data_f;
  logic             ready_b, valid_b, last_b, busy;
  logic [L-1:0]     data_b;
  logic [IDW-1:0]   grant_id;

  rr_stream_arbiter #(.L(L), .N(N), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .valid_f(valid_f), .ready_f(ready_f), .data_f(data_f),
    .last_f(last_f), .ready_b(ready_b), .valid_b(valid_b), .data_b(data_b),
    .last_b(last_b), .grant_id(grant_id), .busy(busy));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cyc = 0;

  // per-requester packet source: ring of {last, data}
  logic [L:0] qm [N][64];
  int qh [N], qc [N];
  bit stall [N];
  int rb_mode = 1;       // 0: ready_b low, 1: high, 2: random
  bit rand_mode = 0;

  // reference model state
  int m_lock, m_owner, m_ptr, m_vb, m_lb, m_gid;
  logic [L-1:0] m_db;

  // log of beats seen on the DUT output
  int log_gid [64], log_data [64], log_last [64], log_cyc [64];
  int nlog = 0;
  bit prev_vb = 0, prev_rb = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int r, input logic [L-1:0] d, input bit l);
    qm[r][(qh[r] + qc[r]) % 64] = {l, d};
    qc[r]++;
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      valid_f[i] = (qc[i] > 0) && !stall[i];
      {last_f[i], data_f[i*L +: L]} = (qc[i] > 0) ? qm[i][qh[i]] : '0;
    end
    case (rb_mode)
      0:       ready_b = 1'b0;
      1:       ready_b = 1'b1;
      default: ready_b = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic model_clear();
    m_lock = 0; m_owner = 0; m_ptr = 0; m_vb = 0; m_lb = 0; m_gid = 0; m_db = '0;
  endtask

  // One clock: compare at negedge, advance the model at posedge, drive new inputs.
  task automatic cycle();
    bit out_rdy, xfer, was_lock;
    logic [N-1:0] exp_rf;
    @(negedge clk);
    out_rdy = ready_b || (m_vb == 0);
    exp_rf  = '0;
    if (m_lock != 0 && out_rdy) exp_rf[m_owner] = 1'b1;
    check("valid_b",  valid_b,  m_vb);
    check("busy",     busy,     m_lock);
    check("ready_f",  ready_f,  exp_rf);
    check("grant_id", grant_id, m_gid);
    check("data_b",   data_b,   m_db);
    check("last_b",   last_b,   m_lb);
    if (valid_b && (!prev_vb || prev_rb) && nlog < 64) begin
      log_gid[nlog] = grant_id; log_data[nlog] = data_b;
      log_last[nlog] = last_b;  log_cyc[nlog] = cyc;
      nlog++;
    end
    prev_vb = valid_b;
    prev_rb = ready_b;
    @(posedge clk);
    cyc++;
    was_lock = (m_lock != 0);
    xfer = was_lock && valid_f[m_owner] && out_rdy;
    if (xfer) begin
      m_vb  = 1;
      {m_lb, m_db} = {1'b0, qm[m_owner][qh[m_owner]]};
      m_lb  = qm[m_owner][qh[m_owner]][L];
      m_gid = m_owner;
      qh[m_owner] = (qh[m_owner] + 1) % 64;
      qc[m_owner]--;
      if (m_lb != 0) begin
        m_lock = 0;
        m_ptr  = (m_owner + 1) % N;
      end
    end else if (m_vb != 0 && ready_b) begin
      m_vb = 0;
    end
    if (!was_lock) begin
      for (int k = 0; k < N; k++) begin
        if (m_lock == 0 && valid_f[(m_ptr + k) % N]) begin
          m_lock  = 1;
          m_owner = (m_ptr + k) % N;
        end
      end
    end
    for (int i = 0; i < N; i++) stall[i] = rand_mode && ($urandom_range(0, 7) == 0);
    #1;
    apply();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_log(input int n, input int limit);
    int g = 0;
    while (nlog < n && g < limit) begin
      cycle();
      g++;
    end
    check("wait_log", (nlog >= n), 1);
  endtask

  // Asynchronous reset: outputs must clear without a clock edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_valid_b",  valid_b,  0);
    check("rst_busy",     busy,     0);
    check("rst_ready_f",  ready_f,  0);
    check("rst_grant_id", grant_id, 0);
    check("rst_data_b",   data_b,   0);
    check("rst_last_b",   last_b,   0);
    model_clear();
    for (int i = 0; i < N; i++) begin qh[i] = 0; qc[i] = 0; stall[i] = 0; end
    rb_mode = 1;
    rand_mode = 0;
    apply();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    prev_vb = 0; prev_rb = 0; nlog = 0;
  endtask

  initial begin
    int pc;
    valid_f = '0; last_f = '0; data_f = '0; ready_b = 1'b1;
    do_reset();

    // idle after reset
    run(10);
    check("idle_nlog", nlog, 0);

    // requester 2: three-beat packet, then requesters 1 and 3 compete from ptr=3
    push(2, 8'h11, 0); push(2, 8'h22, 0); push(2, 8'h33, 1);
    pc = cyc;
    apply();
    wait_log(3, 20);
    check("t2_lat",   log_cyc[0] - pc, 2);
    check("t2_d0",    log_data[0], 8'h11);
    check("t2_d1",    log_data[1], 8'h22);
    check("t2_d2",    log_data[2], 8'h33);
    check("t2_l0",    log_last[0], 0);
    check("t2_l2",    log_last[2], 1);
    check("t2_gid",   log_gid[2],  2);
    check("t2_back",  log_cyc[2] - log_cyc[0], 2);
    push(1, 8'h61, 1); push(3, 8'h63, 1);
    apply();
    wait_log(5, 20);
    check("t2_ptr3",  log_gid[3], 3);
    check("t2_next",  log_gid[4], 1);
    run(4);

    // all four requesters, single-beat packets: strict rotation
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(i, 8'hA0 + 8'(i), 1);
    apply();
    wait_log(8, 40);
    for (int k = 0; k < 8; k++) begin
      check("t3_gid",  log_gid[k],  k % N);
      check("t3_data", log_data[k], 8'hA0 + (k % N));
    end
    check("t3_gap", log_cyc[1] - log_cyc[0], 2);
    run(4);

    // ptr wrap from 3 to 0
    do_reset();
    push(2, 8'h02, 1); apply(); wait_log(1, 10); run(3);
    push(3, 8'h03, 1); apply(); wait_log(2, 10); run(3);
    push(3, 8'h33, 1); push(0, 8'h00, 1); apply();
    wait_log(4, 20);
    check("t4_g0", log_gid[0], 2);
    check("t4_g1", log_gid[1], 3);
    check("t4_wrap", log_gid[2], 0);
    check("t4_g3", log_gid[3], 3);
    run(3);

    // downstream stall mid-packet with a competing requester
    do_reset();
    push(1, 8'h51, 0); push(1, 8'h52, 0); push(1, 8'h53, 1);
    apply();
    wait_log(1, 10);
    push(0, 8'h0F, 1);
    rb_mode = 0;
    apply();
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t5_hold", data_b, 8'h52);
      check("t5_rdyf", ready_f, 0);
    end
    rb_mode = 1;
    apply();
    wait_log(4, 20);
    check("t5_d2",  log_data[2], 8'h53);
    check("t5_g2",  log_gid[2],  1);
    check("t5_d3",  log_data[3], 8'h0F);
    check("t5_g3",  log_gid[3],  0);
    run(3);

    // reset mid-packet, then arbitration restarts at ptr=0
    do_reset();
    push(1, 8'h71, 1); apply(); wait_log(1, 10); run(3);
    push(2, 8'h81, 0); push(2, 8'h82, 0); push(2, 8'h83, 0); push(2, 8'h84, 1);
    apply();
    wait_log(2, 10);
    rb_mode = 0; apply();
    cycle();
    check("t6_pre_vb",   valid_b, 1);
    check("t6_pre_busy", busy,    1);
    do_reset();
    push(3, 8'h93, 1); push(0, 8'h90, 1); apply();
    wait_log(2, 20);
    check("t6_first", log_gid[0], 0);
    check("t6_second", log_gid[1], 3);
    run(3);

    // randomized traffic
    do_reset();
    rb_mode = 2;
    rand_mode = 1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (qc[i] < 50 && $urandom_range(0, 5) == 0) begin
          int nb = $urandom_range(1, 4);
          for (int b = 0; b < nb; b++) push(i, 8'($urandom), (b == nb - 1));
        end
      end
      cycle();
    end
    rand_mode = 0;
    rb_mode = 1;
    for (int i = 0; i < N; i++) stall[i] = 0;
    apply();
    run(500);
    check("rand_drained", qc[0] + qc[1] + qc[2] + qc[3], 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
